// File: rtl/fu_arith_pipe.sv
// Two-stage A64 ADD/SUB(S) execution unit (immediate and shifted-register forms).
// Stage 1 decodes and registers operands; stage 2 adds and registers result and flags.
module fu_arith_pipe #(
  parameter int unsigned PRN_W = 7,
  parameter int unsigned ID_W  = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      inst,
  input  logic [63:0]      op_a,
  input  logic [63:0]      op_b,
  input  logic [PRN_W-1:0] in_prn,
  input  logic [ID_W-1:0]  in_id,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [63:0]      out_result,
  output logic             out_result_valid,
  output logic [3:0]       out_flags,
  output logic             out_flags_valid,
  output logic             out_illegal,
  output logic [PRN_W-1:0] out_prn,
  output logic [ID_W-1:0]  out_id
);

  localparam int unsigned XLEN = 64;
  localparam int unsigned WLEN = 32;

  // decode
  logic            is_imm_c, is_reg_c, sf_c, sub_c, s_c, illegal_c;
  logic [1:0]      shift_c;
  logic [5:0]      imm6_c;
  logic [WLEN-1:0] bw_c;
  logic [XLEN-1:0] bop_c;
  logic            unused_c;

  assign unused_c = ^inst[9:5];

  always_comb begin
    is_imm_c  = (inst[28:23] == 6'b100010);
    is_reg_c  = (inst[28:24] == 5'b01011) && !inst[21];
    sf_c      = inst[31];
    sub_c     = inst[30];
    s_c       = inst[29];
    shift_c   = inst[23:22];
    imm6_c    = inst[15:10];
    bw_c      = '0;
    bop_c     = '0;
    if (is_imm_c) begin
      bop_c = inst[22] ? (XLEN'(inst[21:10]) << 12) : XLEN'(inst[21:10]);
    end else if (sf_c) begin
      case (shift_c)
        2'b00:   bop_c = op_b << imm6_c;
        2'b01:   bop_c = op_b >> imm6_c;
        2'b10:   bop_c = $unsigned($signed(op_b) >>> imm6_c);
        default: bop_c = '0;
      endcase
    end else begin
      // W forms shift within 32 bits so ASR replicates bit 31
      case (shift_c)
        2'b00:   bw_c = op_b[31:0] << imm6_c[4:0];
        2'b01:   bw_c = op_b[31:0] >> imm6_c[4:0];
        2'b10:   bw_c = $unsigned($signed(op_b[31:0]) >>> imm6_c[4:0]);
        default: bw_c = '0;
      endcase
      bop_c = {32'b0, bw_c};
    end
    if (sub_c) bop_c = ~bop_c;
    illegal_c = !(is_imm_c || is_reg_c) ||
                (is_reg_c && ((shift_c == 2'b11) || (!sf_c && imm6_c[5])));
  end

  // handshake
  logic s1_valid, s2_valid;
  logic s1_adv_c, accept_c;

  assign s1_adv_c  = !s2_valid || out_ready;
  assign in_ready  = flush || !s1_valid || s1_adv_c;
  assign accept_c  = in_valid && in_ready && !flush;
  assign out_valid = s2_valid;

  // stage 1 registers
  logic [XLEN-1:0]  s1_a, s1_b;
  logic             s1_cin, s1_sf, s1_ill, s1_rv, s1_fv;
  logic [PRN_W-1:0] s1_prn;
  logic [ID_W-1:0]  s1_id;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_cin   <= 1'b0;
      s1_sf    <= 1'b0;
      s1_ill   <= 1'b0;
      s1_rv    <= 1'b0;
      s1_fv    <= 1'b0;
      s1_prn   <= '0;
      s1_id    <= '0;
    end else begin
      if (flush)         s1_valid <= 1'b0;
      else if (accept_c) s1_valid <= 1'b1;
      else if (s1_adv_c) s1_valid <= 1'b0;
      if (accept_c) begin
        s1_a   <= op_a;
        s1_b   <= bop_c;
        s1_cin <= sub_c;
        s1_sf  <= sf_c;
        s1_ill <= illegal_c;
        s1_rv  <= !illegal_c && !(s_c && (inst[4:0] == 5'b11111));
        s1_fv  <= !illegal_c && s_c;
        s1_prn <= in_prn;
        s1_id  <= in_id;
      end
    end
  end

  // stage 2 adder and flags at the active width
  logic [XLEN:0]   sum64_c;
  logic [WLEN:0]   sum32_c;
  logic [XLEN-1:0] res_c;
  logic            n_c, z_c, c_c, v_c;

  always_comb begin
    sum64_c = {1'b0, s1_a} + {1'b0, s1_b} + (XLEN+1)'(s1_cin);
    sum32_c = {1'b0, s1_a[31:0]} + {1'b0, s1_b[31:0]} + (WLEN+1)'(s1_cin);
    res_c   = sum64_c[XLEN-1:0];
    n_c     = sum64_c[63];
    c_c     = sum64_c[64];
    v_c     = (s1_a[63] == s1_b[63]) && (sum64_c[63] != s1_a[63]);
    if (!s1_sf) begin
      res_c = {32'b0, sum32_c[31:0]};
      n_c   = sum32_c[31];
      c_c   = sum32_c[32];
      v_c   = (s1_a[31] == s1_b[31]) && (sum32_c[31] != s1_a[31]);
    end
    z_c = (res_c == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid         <= 1'b0;
      out_result       <= '0;
      out_flags        <= '0;
      out_result_valid <= 1'b0;
      out_flags_valid  <= 1'b0;
      out_illegal      <= 1'b0;
      out_prn          <= '0;
      out_id           <= '0;
    end else begin
      if (flush)         s2_valid <= 1'b0;
      else if (s1_adv_c) s2_valid <= s1_valid;
      if (!flush && s1_adv_c && s1_valid) begin
        out_result       <= res_c;
        out_flags        <= {n_c, z_c, c_c, v_c};
        out_result_valid <= s1_rv;
        out_flags_valid  <= s1_fv;
        out_illegal      <= s1_ill;
        out_prn          <= s1_prn;
        out_id           <= s1_id;
      end
    end
  end

endmodule

// File: tb/tb_fu_arith_pipe.sv
// Directed bench for fu_arith_pipe: hand-computed results, stall, flush and reset behaviour.
module tb_fu_arith_pipe;

  localparam int unsigned PRN_W = 7;
  localparam int unsigned ID_W  = 6;

  logic             clk = 1'b0;
  logic             rst_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0]      inst;
  logic [63:0]      op_a, op_b, out_result;
  logic [PRN_W-1:0] in_prn, out_prn;
  logic [ID_W-1:0]  in_id, out_id;
  logic [3:0]       out_flags;
  logic             out_result_valid, out_flags_valid, out_illegal;

  int n_checks = 0;
  int n_pass   = 0;

  fu_arith_pipe #(.PRN_W(PRN_W), .ID_W(ID_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .inst(inst),
    .op_a(op_a), .op_b(op_b), .in_prn(in_prn), .in_id(in_id),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_result_valid(out_result_valid), .out_flags(out_flags),
    .out_flags_valid(out_flags_valid), .out_illegal(out_illegal),
    .out_prn(out_prn), .out_id(out_id)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic drive(input logic [31:0] i, input logic [63:0] a, input logic [63:0] b,
                       input logic [ID_W-1:0] id);
    inst   = i;
    op_a   = a;
    op_b   = b;
    in_id  = id;
    in_prn = PRN_W'(id) + 7'd40;
  endtask

  // issue one op into an empty pipe and check it appears exactly 2 cycles later
  task automatic run_op(input string tag, input logic [31:0] i, input logic [63:0] a,
                        input logic [63:0] b, input logic [ID_W-1:0] id,
                        input logic [63:0] exp_res, input logic [3:0] exp_fl,
                        input logic exp_rv, input logic exp_fv, input logic exp_ill);
    @(negedge clk);
    drive(i, a, b, id);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    check({tag, ".in_ready"}, 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check({tag, ".early"}, 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    check({tag, ".valid"}, 64'(out_valid), 64'd1);
    check({tag, ".ill"}, 64'(out_illegal), 64'(exp_ill));
    check({tag, ".rv"}, 64'(out_result_valid), 64'(exp_rv));
    check({tag, ".fv"}, 64'(out_flags_valid), 64'(exp_fv));
    if (exp_rv) check({tag, ".res"}, out_result, exp_res);
    if (exp_fv) check({tag, ".flags"}, 64'(out_flags), 64'(exp_fl));
    check({tag, ".id"}, 64'(out_id), 64'(id));
    check({tag, ".prn"}, 64'(out_prn), 64'(PRN_W'(id) + 7'd40));
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b1;
    end
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    drive(32'h0, 64'h0, 64'h0, 6'd0);
    #12;
    check("rst.out_valid", 64'(out_valid), 64'd0);
    check("rst.in_ready", 64'(in_ready), 64'd1);
    check("rst.result", out_result, 64'd0);
    check("rst.flags", 64'(out_flags), 64'd0);
    check("rst.ill", 64'(out_illegal), 64'd0);
    @(negedge clk); rst_n = 1'b1;

    run_op("subs_x",   32'hEB030041, 64'd5, 64'd5, 6'd1, 64'd0, 4'b0110, 1'b1, 1'b1, 1'b0);
    run_op("cmp_w",    32'h6B03005F, 64'h0000_0000_8000_0000, 64'd1, 6'd2,
           64'h0000_0000_7FFF_FFFF, 4'b0011, 1'b0, 1'b1, 1'b0);
    run_op("add_imm",  32'h91400420, 64'hFFFF, 64'd0, 6'd3, 64'h10FFF, 4'b0000, 1'b1, 1'b0, 1'b0);
    run_op("adds_asr", 32'hAB821020, 64'd0, 64'hFFFF_FFFF_FFFF_FF00, 6'd4,
           64'hFFFF_FFFF_FFFF_FFF0, 4'b1000, 1'b1, 1'b1, 1'b0);
    run_op("shift11",  32'h8BC30041, 64'd1, 64'd1, 6'd5, 64'd0, 4'b0000, 1'b0, 1'b0, 1'b1);
    run_op("w_imm32",  32'h0B038041, 64'd1, 64'd1, 6'd6, 64'd0, 4'b0000, 1'b0, 1'b0, 1'b1);
    run_op("noclass",  32'h00000000, 64'd1, 64'd1, 6'd7, 64'd0, 4'b0000, 1'b0, 1'b0, 1'b1);
    run_op("adds_wv",  32'h2B020020, 64'hDEAD_0000_7FFF_FFFF, 64'h1234_5678_0000_0001, 6'd8,
           64'h0000_0000_8000_0000, 4'b1001, 1'b1, 1'b1, 1'b0);
    run_op("add_lsr",  32'h8B422020, 64'd1, 64'h1234_0000_0000_0000, 6'd9,
           64'h0012_3400_0000_0001, 4'b0000, 1'b1, 1'b0, 1'b0);
    run_op("adds_xc",  32'hAB020020, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 6'd10,
           64'd0, 4'b0110, 1'b1, 1'b1, 1'b0);
    run_op("sub_imm",  32'hD1000420, 64'd0, 64'd0, 6'd11,
           64'hFFFF_FFFF_FFFF_FFFF, 4'b0000, 1'b1, 1'b0, 1'b0);
    run_op("subs_wb",  32'h6B020020, 64'd1, 64'd2, 6'd12,
           64'h0000_0000_FFFF_FFFF, 4'b1000, 1'b1, 1'b1, 1'b0);
    run_op("adds_wasr", 32'h2B821020, 64'd0, 64'h0000_0000_8000_0000, 6'd13,
           64'h0000_0000_F800_0000, 4'b1000, 1'b1, 1'b1, 1'b0);
    idle(2);

    // back-to-back ops under a consumer stall (ADD X0,X1,#1 gives a+1)
    @(negedge clk);
    drive(32'h91000420, 64'd100, 64'd0, 6'd20); in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    check("stall.in_ready1", 64'(in_ready), 64'd1);
    @(negedge clk); drive(32'h91000420, 64'd200, 64'd0, 6'd21);
    @(posedge clk); #1;
    check("stall.valid", 64'(out_valid), 64'd1);
    check("stall.first_id", 64'(out_id), 64'd20);
    check("stall.in_ready0", 64'(in_ready), 64'd0);
    @(negedge clk); drive(32'h91000420, 64'd300, 64'd0, 6'd22);
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      check("stall.hold_id", 64'(out_id), 64'd20);
      check("stall.hold_res", out_result, 64'd101);
      check("stall.hold_rdy", 64'(in_ready), 64'd0);
    end
    @(negedge clk); out_ready = 1'b1; #1;
    check("stall.ready_comb", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("order.second", 64'(out_id), 64'd21);
    check("order.second_res", out_result, 64'd201);
    @(posedge clk); #1;
    check("order.third", 64'(out_id), 64'd22);
    check("order.third_res", out_result, 64'd301);
    @(posedge clk); #1;
    check("order.drained", 64'(out_valid), 64'd0);

    // fill both stages, then flush with a colliding request
    @(negedge clk);
    drive(32'h91000420, 64'd1, 64'd0, 6'd30); in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk); drive(32'h91000420, 64'd2, 64'd0, 6'd31);
    @(negedge clk); drive(32'h91000420, 64'd3, 64'd0, 6'd32); flush = 1'b1; #1;
    check("flush.full_valid", 64'(out_valid), 64'd1);
    check("flush.in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    check("flush.cleared", 64'(out_valid), 64'd0);
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check("flush.empty", 64'(out_valid), 64'd0);
    end

    // reset mid-stall discards held ops
    @(negedge clk);
    drive(32'h91000420, 64'd7, 64'd0, 6'd40); in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk); drive(32'h91000420, 64'd8, 64'd0, 6'd41);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("rstmid.full", 64'(out_valid), 64'd1);
    #2 rst_n = 1'b0; #1;
    check("rstmid.valid", 64'(out_valid), 64'd0);
    check("rstmid.in_ready", 64'(in_ready), 64'd1);
    check("rstmid.result", out_result, 64'd0);
    check("rstmid.id", 64'(out_id), 64'd0);
    check("rstmid.prn", 64'(out_prn), 64'd0);
    check("rstmid.rv", 64'(out_result_valid), 64'd0);
    @(negedge clk); rst_n = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    check("rstmid.gone", 64'(out_valid), 64'd0);
    run_op("post_rst", 32'h91000420, 64'd41, 64'd0, 6'd42, 64'd42, 4'b0000, 1'b1, 1'b0, 1'b0);
    idle(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
